// File: rtl/accum_seq_ctrl.sv
// Multi-pass popcount accumulation sequencer: strips the datapath offset, sums per-lane
// counts across channel tiles, and presents saturated totals plus thresholded activations.
module accum_seq_ctrl #(
  parameter int KERNEL_SIZE = 9,
  parameter int CHANNEL_CNT = 16,
  parameter int BIT_WIDTH   = 8,
  parameter int SUM_WIDTH   = 16,
  parameter int PASS_WIDTH  = 7
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [PASS_WIDTH-1:0]              cfg_passes_i,
  input  logic [SUM_WIDTH-1:0]               thr_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [KERNEL_SIZE*CHANNEL_CNT-1:0] in_data_i,
  output logic [KERNEL_SIZE*CHANNEL_CNT-1:0] xnor_o,
  input  logic [KERNEL_SIZE*BIT_WIDTH-1:0]   acc_result_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [KERNEL_SIZE*SUM_WIDTH-1:0]   out_sum_o,
  output logic [KERNEL_SIZE-1:0]             out_bin_o,
  output logic [PASS_WIDTH-1:0]              pass_cnt_o,
  output logic                               busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [BIT_WIDTH-1:0] OFFSET = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  state_t                           state_r, state_s;
  logic [PASS_WIDTH-1:0]            passes_r, passes_s, pass_cnt_r, pass_cnt_s;
  logic [PASS_WIDTH-1:0]            cfg_eff_s, passes_eff_s, pass_inc_s;
  logic [SUM_WIDTH-1:0]             thr_r, thr_s, thr_eff_s;
  logic [KERNEL_SIZE*SUM_WIDTH-1:0] sum_r, sum_s, lane_sum_s;
  logic [KERNEL_SIZE-1:0]           bin_r, bin_s, lane_bin_s;
  logic                             in_ready_r, in_ready_s;
  logic                             out_valid_r, out_valid_s;
  logic                             busy_r, busy_s;
  logic                             accept_s, first_s, last_s;

  assign xnor_o   = in_data_i;
  assign accept_s = in_valid_i & in_ready_r;
  assign first_s  = (state_r == IDLE);

  // Config and threshold come from the ports only on a frame's first tile.
  assign cfg_eff_s    = (cfg_passes_i == {PASS_WIDTH{1'b0}}) ? {{(PASS_WIDTH-1){1'b0}}, 1'b1}
                                                             : cfg_passes_i;
  assign passes_eff_s = first_s ? cfg_eff_s : passes_r;
  assign thr_eff_s    = first_s ? thr_i : thr_r;
  assign pass_inc_s   = first_s ? {{(PASS_WIDTH-1){1'b0}}, 1'b1}
                                : pass_cnt_r + {{(PASS_WIDTH-1){1'b0}}, 1'b1};
  assign last_s       = (pass_inc_s == passes_eff_s);

  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_lane
    logic [BIT_WIDTH-1:0] cnt_s;
    logic [SUM_WIDTH-1:0] base_s;
    logic [SUM_WIDTH:0]   add_s;

    assign cnt_s  = acc_result_i[i*BIT_WIDTH +: BIT_WIDTH] - OFFSET;
    assign base_s = first_s ? {SUM_WIDTH{1'b0}} : sum_r[i*SUM_WIDTH +: SUM_WIDTH];
    assign add_s  = {1'b0, base_s} + {{(SUM_WIDTH+1-BIT_WIDTH){1'b0}}, cnt_s};
    // A carry out of the running sum pins the lane at full scale.
    assign lane_sum_s[i*SUM_WIDTH +: SUM_WIDTH] = add_s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}}
                                                                   : add_s[SUM_WIDTH-1:0];
    assign lane_bin_s[i] = (lane_sum_s[i*SUM_WIDTH +: SUM_WIDTH] >= thr_eff_s);
  end

  // Next-state, datapath-load and output-flag decode.
  always_comb begin
    state_s    = state_r;
    passes_s   = passes_r;
    thr_s      = thr_r;
    sum_s      = sum_r;
    bin_s      = bin_r;
    pass_cnt_s = pass_cnt_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (accept_s) begin
          passes_s   = passes_eff_s;
          thr_s      = thr_eff_s;
          sum_s      = lane_sum_s;
          pass_cnt_s = pass_inc_s;
          if (last_s) begin
            state_s = DONE;
            bin_s   = lane_bin_s;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        // Sums and activations stay visible after hand-off; only the frame state clears.
        if (out_ready_i) begin
          state_s    = IDLE;
          pass_cnt_s = {PASS_WIDTH{1'b0}};
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s    = IDLE;
        pass_cnt_s = {PASS_WIDTH{1'b0}};
      end
    endcase
    in_ready_s  = (state_s != DONE);
    out_valid_s = (state_s == DONE);
    busy_s      = (state_s != IDLE);
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      passes_r    <= {PASS_WIDTH{1'b0}};
      thr_r       <= {SUM_WIDTH{1'b0}};
      sum_r       <= {(KERNEL_SIZE*SUM_WIDTH){1'b0}};
      bin_r       <= {KERNEL_SIZE{1'b0}};
      pass_cnt_r  <= {PASS_WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      passes_r    <= passes_s;
      thr_r       <= thr_s;
      sum_r       <= sum_s;
      bin_r       <= bin_s;
      pass_cnt_r  <= pass_cnt_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_sum_o   = sum_r;
  assign out_bin_o   = bin_r;
  assign pass_cnt_o  = pass_cnt_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl: default instance plus an 8-bit-sum instance for saturation.
module tb_accum_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   cfg_passes;
  logic [15:0]  thr;
  logic         in_valid;
  logic         in_ready;
  logic [143:0] in_data;
  logic [143:0] xnor_out;
  logic [71:0]  acc_result;
  logic         out_valid;
  logic         out_ready;
  logic [143:0] out_sum;
  logic [8:0]   out_bin;
  logic [6:0]   pass_cnt;
  logic         busy;

  logic [6:0]   cfg8;
  logic [7:0]   thr8;
  logic         v8, r8, ov8, or8, busy8;
  logic [143:0] d8, x8;
  logic [71:0]  acc8, sum8;
  logic [8:0]   bin8;
  logic [6:0]   pc8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  accum_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cfg_passes_i(cfg_passes), .thr_i(thr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .xnor_o(xnor_out),
    .acc_result_i(acc_result), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_bin_o(out_bin), .pass_cnt_o(pass_cnt), .busy_o(busy)
  );

  accum_seq_ctrl #(.SUM_WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .cfg_passes_i(cfg8), .thr_i(thr8),
    .in_valid_i(v8), .in_ready_o(r8), .in_data_i(d8), .xnor_o(x8),
    .acc_result_i(acc8), .out_valid_o(ov8), .out_ready_i(or8),
    .out_sum_o(sum8), .out_bin_o(bin8), .pass_cnt_o(pc8), .busy_o(busy8)
  );

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] all_lanes(input logic [7:0] c);
    logic [7:0] v;
    v = 8'd128 + c;
    return {9{v}};
  endfunction

  function automatic logic [71:0] lane0(input logic [7:0] c);
    logic [7:0] v;
    v = 8'd128 + c;
    return {{8{8'd128}}, v};
  endfunction

  // Present one tile, wait (bounded) for ready, and return 1 time unit after the accepting edge.
  task automatic send(input logic [71:0] acc);
    int n;
    n = 0;
    in_valid   = 1'b1;
    acc_result = acc;
    in_data    = {$urandom, $urandom, $urandom, $urandom, $urandom};
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("send_ready_timeout", (n >= 50), 1'b0);
    check_val("xnor_passthru", xnor_out, in_data);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    acc_result = {9{8'hFF}};
  endtask

  task automatic send8(input logic [71:0] acc);
    v8   = 1'b1;
    acc8 = acc;
    @(posedge clk); #1;
    v8   = 1'b0;
    acc8 = {9{8'hFF}};
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_passes = 7'd1; thr = 16'd0; in_valid = 1'b0; in_data = '0;
    acc_result = {9{8'hFF}}; out_ready = 1'b0;
    cfg8 = 7'd1; thr8 = 8'd0; v8 = 1'b0; d8 = '0; acc8 = {9{8'hFF}}; or8 = 1'b0;
    #12;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_sum", out_sum, 144'd0);
    check_val("rst_out_bin", out_bin, 9'd0);
    check_val("rst_pass_cnt", pass_cnt, 7'd0);
    check_val("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single pass, all lanes count 16, thr 8.
    cfg_passes = 7'd1; thr = 16'd8;
    send(all_lanes(8'd16));
    check_val("t1_valid", out_valid, 1'b1);
    check_val("t1_sum", out_sum, {9{16'd16}});
    check_val("t1_bin", out_bin, 9'h1FF);
    check_val("t1_in_ready", in_ready, 1'b0);
    check_val("t1_busy", busy, 1'b1);
    consume;
    check_val("t1_valid_clr", out_valid, 1'b0);
    check_val("t1_pass_clr", pass_cnt, 7'd0);
    check_val("t1_busy_clr", busy, 1'b0);
    check_val("t1_sum_hold", out_sum, {9{16'd16}});

    // Four passes on lane 0 only.
    cfg_passes = 7'd4; thr = 16'd20;
    send(lane0(8'd3));  check_val("t2_pc1", pass_cnt, 7'd1); check_val("t2_v1", out_valid, 1'b0);
    send(lane0(8'd5));  check_val("t2_pc2", pass_cnt, 7'd2); check_val("t2_v2", out_valid, 1'b0);
    send(lane0(8'd0));  check_val("t2_pc3", pass_cnt, 7'd3); check_val("t2_v3", out_valid, 1'b0);
    send(lane0(8'd16)); check_val("t2_pc4", pass_cnt, 7'd4); check_val("t2_v4", out_valid, 1'b1);
    check_val("t2_sum", out_sum, {{8{16'd0}}, 16'd24});
    check_val("t2_bin", out_bin, 9'h001);
    consume;

    // Three passes with idle gaps, stalled output, and a tile waiting through DONE.
    cfg_passes = 7'd3; thr = 16'd60;
    send(all_lanes(8'd10));
    repeat (2) @(posedge clk); #1;
    send(all_lanes(8'd20));
    repeat (3) @(posedge clk); #1;
    send(all_lanes(8'd30));
    check_val("t3_valid", out_valid, 1'b1);
    check_val("t3_bin", out_bin, 9'h1FF);
    in_valid = 1'b1; acc_result = all_lanes(8'd50); cfg_passes = 7'd1; thr = 16'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("t3_hold_valid", out_valid, 1'b1);
      check_val("t3_hold_ready", in_ready, 1'b0);
      check_val("t3_hold_sum", out_sum, {9{16'd60}});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("t3_consumed", out_valid, 1'b0);
    check_val("t3_no_overlap", out_sum, {9{16'd60}});
    check_val("t3_ready_back", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("t3_next_valid", out_valid, 1'b1);
    check_val("t3_next_sum", out_sum, {9{16'd50}});
    check_val("t3_next_pc", pass_cnt, 7'd1);
    consume;

    // Asynchronous reset after 2 of 4 passes.
    cfg_passes = 7'd4; thr = 16'd0;
    send(all_lanes(8'd5));
    send(all_lanes(8'd5));
    check_val("t6_pre_pc", pass_cnt, 7'd2);
    check_val("t6_pre_sum", out_sum, {9{16'd10}});
    #2 rst = 1'b1;
    #1;
    check_val("t6_sum", out_sum, 144'd0);
    check_val("t6_bin", out_bin, 9'd0);
    check_val("t6_pc", pass_cnt, 7'd0);
    check_val("t6_busy", busy, 1'b0);
    check_val("t6_ready", in_ready, 1'b1);
    check_val("t6_valid", out_valid, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    cfg_passes = 7'd1;
    send(all_lanes(8'd9));
    check_val("t6_new_valid", out_valid, 1'b1);
    check_val("t6_new_sum", out_sum, {9{16'd9}});
    consume;

    // Zero passes means one; mid-frame config/threshold changes ignored.
    cfg_passes = 7'd0; thr = 16'd0;
    send(all_lanes(8'd7));
    check_val("t4_zero_valid", out_valid, 1'b1);
    check_val("t4_zero_pc", pass_cnt, 7'd1);
    check_val("t4_zero_sum", out_sum, {9{16'd7}});
    consume;
    cfg_passes = 7'd3; thr = 16'd4;
    send(all_lanes(8'd1));
    cfg_passes = 7'd2; thr = 16'd0;
    send(all_lanes(8'd1));
    check_val("t4_not_done", out_valid, 1'b0);
    send(all_lanes(8'd1));
    check_val("t4_done", out_valid, 1'b1);
    check_val("t4_sum", out_sum, {9{16'd3}});
    check_val("t4_bin", out_bin, 9'h000);
    consume;

    // Saturation with 8-bit sums: 20 passes of 16 would be 320.
    cfg8 = 7'd20; thr8 = 8'd255;
    for (int k = 0; k < 20; k++) send8(all_lanes(8'd16));
    check_val("t5_valid", ov8, 1'b1);
    check_val("t5_sum", sum8, {9{8'd255}});
    check_val("t5_bin", bin8, 9'h1FF);
    check_val("t5_pc", pc8, 7'd20);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check_val("t5_consumed", ov8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
